led_gpio_ctrl: RTL and testbench
================================

# led_gpio_ctrl

Memory-mapped LED/GPIO peripheral on the Ibex data bus, replacing the hard-wired "last written byte drives the LEDs" register in the FPGA top level. Provides per-LED static, blink and PWM modes, a programmable blink prescaler, a global PWM duty and a synchronised general-purpose input register. The top level decodes the peripheral region and raises `req_i` only for accesses inside it. SRAM keeps the remaining address space.

## Interface
- `NumLeds`, 8: LED outputs, 1..16.
- `NumGpi`, 8: general-purpose inputs, 1..32.
- `PrescW`, 24: blink prescaler width, 1..32.
- `clk_sys` in 1: system clock.
- `rst_sys_n` in 1: reset, asynchronous, active-low.
- `req_i` in 1: bus request, already region-decoded.
- `we_i` in 1: write enable.
- `be_i` in 4: byte enables.
- `addr_i` in 32: byte address; only `addr_i[4:2]` used.
- `wdata_i` in 32: write data.
- `gnt_o` out 1: grant.
- `rvalid_o` out 1: response valid.
- `rdata_o` out 32: read data.
- `err_o` out 1: response error, valid with `rvalid_o`.
- `gpi_i` in NumGpi: asynchronous inputs (switches/buttons).
- `led_o` out NumLeds: LED drive.

## Operation
- Register map, by word offset `addr_i[4:2]`:
  - 0 `OUT` RW: bits [NumLeds-1:0] give LED enables.
  - 1 `MODE` RW: 2 bits per LED at [2i+1:2i]. Encodings: 00 static, 01 blink, 10 PWM, 11 static.
  - 2 `BLINK_DIV` RW: bits [PrescW-1:0].
  - 3 `PWM_DUTY` RW: bits [7:0].
  - 4 `GPI` RO: bits [NumGpi-1:0], synchronised inputs.
  - 5..7: unmapped.
- Field bits above the implemented width read 0 and ignore writes.
- Writes honour `be_i` per byte.
- A write to `GPI` or to an unmapped offset:
  - has no state effect;
  - responds with `err_o`=1 for unmapped offsets only.
- `GPI` writes are silently ignored with `err_o`=0.
- Reads of unmapped offsets return `rdata_o`=0 and `err_o`=1.
- Blink generator:
  - counter `pcnt` increments every cycle.
  - When `pcnt==BLINK_DIV`, `pcnt`←0 and `blink_ph` toggles.
  - `BLINK_DIV`=0 toggles every cycle. Blink period is 2·(BLINK_DIV+1) cycles.
  - Any write to `BLINK_DIV` clears `pcnt` and `blink_ph` in the same cycle it updates the register.
- PWM generator:
  - 8-bit free-running `wcnt`, wraps 255→0.
  - `pwm_on` = (`wcnt` < `PWM_DUTY`).
  - Duty 0 gives always off; 255 gives on 255 of 256 cycles.
- Per LED `i`, the next value of `led_o[i]` is:
  - static: `OUT[i]`;
  - blink: `OUT[i] & blink_ph`;
  - PWM: `OUT[i] & pwm_on`.
- `gpi_i` passes through a 2-flop synchroniser before `GPI`.
- Reset values: all registers, counters, `blink_ph`, `led_o`, `rvalid_o`, `rdata_o` and `err_o` are 0.
- A reset mid-operation drops any pending response; no `rvalid_o` follows after release.

## Timing
- `gnt_o` = `req_i`, combinational. Every request is accepted in its cycle, with no back-pressure.
- Response timing:
  - `rvalid_o` is asserted exactly 1 cycle after each accepted request, reads and writes alike, for one cycle.
  - `rdata_o` and `err_o` are registered and valid only with `rvalid_o`.
  - `rdata_o` is 0 for writes.
- Back-to-back requests on consecutive cycles produce consecutive `rvalid_o` pulses.
- A write in cycle N:
  - updates the register at edge N+1;
  - reaches `led_o` at edge N+2, because `led_o` is registered.
- A read in the same cycle as a write to the same register returns the old value.
- `GPI` latency from a `gpi_i` change to a readable value is 2 to 3 cycles.

## Structure
- Package `led_gpio_pkg` holds:
  - register offset constants `OUT_OFS`..`GPI_OFS`;
  - the `led_mode_e` enum: `LedStatic`, `LedBlink`, `LedPwm`;
  - a function extracting the per-LED mode from `MODE`.
- Sub-module `led_pwm_gen` holds the blink prescaler and PWM counter.
  - Inputs: `BLINK_DIV`, `PWM_DUTY`, and a clear strobe for blink writes.
  - Outputs: `blink_ph`, `pwm_on`.
- Top-level instantiation:
  - `req_i` is driven by region select `data_addr[31:12]==20'h10000`;
  - the SRAM/peripheral `rvalid`/`rdata` mux is steered by a registered select.

## Test plan
- Reset then read of each offset 0..4 with `gpi_i`=0:
  - returns 0 with `err_o`=0;
  - `led_o`=0 throughout.
- Write `OUT`=0xA5 with `MODE`=0 → `led_o`=0xA5 exactly 2 cycles after the request. A write with `be_i`=4'b0010 and data 0xFF00 leaves `OUT` unchanged for NumLeds=8.
- Set `MODE`=0x0001 (LED0 blink), `BLINK_DIV`=3, `OUT`=0x01:
  - `led_o[0]` toggles every 4 cycles, period 8;
  - rewriting `BLINK_DIV` restarts the phase low.
- Set `MODE`=0x0002 (LED0 PWM), `OUT`=0x01, `PWM_DUTY`=64 → over 256 cycles, `led_o[0]` is high exactly 64 cycles. Duty 0 gives 0 high cycles; duty 255 gives 255.
- Read or write offset 6 → `rvalid_o` pulses next cycle with `err_o`=1, `rdata_o`=0, and no register changes.
- Drive `gpi_i`=0x3C asynchronously → `GPI` read returns 0x3C within 3 cycles. Back-to-back read/write/read sequences give three consecutive `rvalid_o` pulses.

Source files
------------

// File: rtl/led_gpio_pkg.sv
// led_gpio_pkg: shared definitions for the LED/GPIO peripheral.
//   - Word offsets of the register map (addr[4:2]).
//   - Per-LED mode enum and a helper that extracts one LED's mode from MODE.
package led_gpio_pkg;

  localparam logic [2:0] OUT_OFS       = 3'd0;
  localparam logic [2:0] MODE_OFS      = 3'd1;
  localparam logic [2:0] BLINK_DIV_OFS = 3'd2;
  localparam logic [2:0] PWM_DUTY_OFS  = 3'd3;
  localparam logic [2:0] GPI_OFS       = 3'd4;

  typedef enum logic [1:0] {
    LedStatic = 2'b00,
    LedBlink  = 2'b01,
    LedPwm    = 2'b10
  } led_mode_e;

  // Encoding 11 is treated as static, same as 00.
  function automatic led_mode_e led_mode_get(input logic [31:0] mode, input int unsigned idx);
    logic [1:0] field;
    field = 2'(mode >> (2 * idx));
    case (field)
      2'b01:   return LedBlink;
      2'b10:   return LedPwm;
      default: return LedStatic;
    endcase
  endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// led_pwm_gen: blink prescaler and free-running PWM counter.
//   clk_sys, rst_sys_n : clock, async active-low reset
//   blink_div_i        : prescaler terminal count (phase toggles when pcnt hits it)
//   pwm_duty_i         : PWM duty, on while counter < duty
//   blink_clr_i        : restart blink phase low (strobe on BLINK_DIV write)
//   blink_ph_o         : blink phase
//   pwm_on_o           : PWM on indication
module led_pwm_gen #(
  parameter int unsigned PrescW = 24
) (
  input  logic              clk_sys,
  input  logic              rst_sys_n,
  input  logic [PrescW-1:0] blink_div_i,
  input  logic [7:0]        pwm_duty_i,
  input  logic              blink_clr_i,
  output logic              blink_ph_o,
  output logic              pwm_on_o
);

  logic [PrescW-1:0] pcnt_q, pcnt_d;
  logic              ph_q, ph_d;
  logic [7:0]        wcnt_q;

  always_comb begin
    pcnt_d = pcnt_q + PrescW'(1);
    ph_d   = ph_q;
    if (blink_clr_i) begin
      pcnt_d = '0;
      ph_d   = 1'b0;
    end else if (pcnt_q == blink_div_i) begin
      pcnt_d = '0;
      ph_d   = ~ph_q;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      pcnt_q <= '0;
      ph_q   <= 1'b0;
      wcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      ph_q   <= ph_d;
      wcnt_q <= wcnt_q + 8'd1;
    end
  end

  assign blink_ph_o = ph_q;
  assign pwm_on_o   = (wcnt_q < pwm_duty_i);

endmodule

// File: rtl/led_gpio_ctrl.sv
// led_gpio_ctrl: memory-mapped LED/GPIO peripheral on the Ibex data bus.
//   clk_sys, rst_sys_n   : clock, async active-low reset
//   req_i/we_i/be_i      : region-decoded request, write enable, byte enables
//   addr_i/wdata_i       : byte address (only [4:2] decoded), write data
//   gnt_o                : grant, always equal to req_i
//   rvalid_o/rdata_o/err_o : one-cycle registered response
//   gpi_i                : asynchronous inputs, 2-flop synchronised into GPI
//   led_o                : registered LED drive
module led_gpio_ctrl
  import led_gpio_pkg::*;
#(
  parameter int unsigned NumLeds = 8,
  parameter int unsigned NumGpi  = 8,
  parameter int unsigned PrescW  = 24
) (
  input  logic               clk_sys,
  input  logic               rst_sys_n,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [3:0]         be_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        wdata_i,
  output logic               gnt_o,
  output logic               rvalid_o,
  output logic [31:0]        rdata_o,
  output logic               err_o,
  input  logic [NumGpi-1:0]  gpi_i,
  output logic [NumLeds-1:0] led_o
);

  logic [NumLeds-1:0]   out_q, out_d;
  logic [2*NumLeds-1:0] mode_q, mode_d;
  logic [PrescW-1:0]    bdiv_q, bdiv_d;
  logic [7:0]           duty_q, duty_d;
  logic [NumGpi-1:0]    gpi_s1_q, gpi_s2_q;
  logic [NumLeds-1:0]   led_q, led_d;
  logic                 rvalid_q, err_q, err_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [31:0]          wmask, mode_pad;
  logic [2:0]           ofs;
  logic                 wr, blink_clr, blink_ph, pwm_on;

  assign gnt_o = req_i;
  assign ofs   = addr_i[4:2];
  assign wr    = req_i & we_i;
  assign wmask = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};

  logic unused_bus;
  assign unused_bus = ^{addr_i[31:5], addr_i[1:0], wdata_i, wmask};

  // Byte-masked register writes; bits above each field width are dropped.
  always_comb begin
    out_d  = out_q;
    mode_d = mode_q;
    bdiv_d = bdiv_q;
    duty_d = duty_q;
    if (wr) begin
      case (ofs)
        OUT_OFS:       out_d  = (out_q & ~wmask[NumLeds-1:0]) |
                                (wdata_i[NumLeds-1:0] & wmask[NumLeds-1:0]);
        MODE_OFS:      mode_d = (mode_q & ~wmask[2*NumLeds-1:0]) |
                                (wdata_i[2*NumLeds-1:0] & wmask[2*NumLeds-1:0]);
        BLINK_DIV_OFS: bdiv_d = (bdiv_q & ~wmask[PrescW-1:0]) |
                                (wdata_i[PrescW-1:0] & wmask[PrescW-1:0]);
        PWM_DUTY_OFS:  duty_d = (duty_q & ~wmask[7:0]) | (wdata_i[7:0] & wmask[7:0]);
        default:       ;
      endcase
    end
  end

  assign blink_clr = wr && (ofs == BLINK_DIV_OFS);

  // Read data carries the pre-write register values; writes return zero data.
  always_comb begin
    rdata_d = '0;
    err_d   = req_i && (ofs > GPI_OFS);
    if (req_i && !we_i) begin
      case (ofs)
        OUT_OFS:       rdata_d[NumLeds-1:0]   = out_q;
        MODE_OFS:      rdata_d[2*NumLeds-1:0] = mode_q;
        BLINK_DIV_OFS: rdata_d[PrescW-1:0]    = bdiv_q;
        PWM_DUTY_OFS:  rdata_d[7:0]           = duty_q;
        GPI_OFS:       rdata_d[NumGpi-1:0]    = gpi_s2_q;
        default:       ;
      endcase
    end
  end

  led_pwm_gen #(
    .PrescW (PrescW)
  ) u_pwm_gen (
    .clk_sys     (clk_sys),
    .rst_sys_n   (rst_sys_n),
    .blink_div_i (bdiv_q),
    .pwm_duty_i  (duty_q),
    .blink_clr_i (blink_clr),
    .blink_ph_o  (blink_ph),
    .pwm_on_o    (pwm_on)
  );

  always_comb begin
    mode_pad                = '0;
    mode_pad[2*NumLeds-1:0] = mode_q;
  end

  for (genvar i = 0; i < NumLeds; i++) begin : g_led
    led_mode_e mode_i;
    assign mode_i   = led_mode_get(mode_pad, i);
    assign led_d[i] = (mode_i == LedBlink) ? (out_q[i] & blink_ph) :
                      (mode_i == LedPwm)   ? (out_q[i] & pwm_on)   : out_q[i];
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      out_q    <= '0;
      mode_q   <= '0;
      bdiv_q   <= '0;
      duty_q   <= '0;
      gpi_s1_q <= '0;
      gpi_s2_q <= '0;
      led_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      mode_q   <= mode_d;
      bdiv_q   <= bdiv_d;
      duty_q   <= duty_d;
      gpi_s1_q <= gpi_i;
      gpi_s2_q <= gpi_s1_q;
      led_q    <= led_d;
      rvalid_q <= req_i;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign led_o    = led_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_led_gpio_ctrl.sv
// tb_led_gpio_ctrl: directed + randomized self-checking bench for led_gpio_ctrl.
// Expected register contents come from a byte-merge model; blink and PWM
// expectations are computed arithmetically from the divider/duty settings.
module tb_led_gpio_ctrl;

  localparam int unsigned NumLeds = 8;
  localparam int unsigned NumGpi  = 8;
  localparam int unsigned PrescW  = 24;

  logic               clk_sys   = 1'b0;
  logic               rst_sys_n = 1'b0;
  logic               req_i     = 1'b0;
  logic               we_i      = 1'b0;
  logic [3:0]         be_i      = '0;
  logic [31:0]        addr_i    = '0;
  logic [31:0]        wdata_i   = '0;
  logic [NumGpi-1:0]  gpi_i     = '0;
  logic               gnt_o, rvalid_o, err_o;
  logic [31:0]        rdata_o;
  logic [NumLeds-1:0] led_o;

  int compared   = 0;
  int mismatched = 0;

  // Model of OUT, MODE, BLINK_DIV, PWM_DUTY.
  logic [31:0] model [4];

  led_gpio_ctrl #(
    .NumLeds (NumLeds),
    .NumGpi  (NumGpi),
    .PrescW  (PrescW)
  ) dut (
    .clk_sys   (clk_sys),
    .rst_sys_n (rst_sys_n),
    .req_i     (req_i),
    .we_i      (we_i),
    .be_i      (be_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .gnt_o     (gnt_o),
    .rvalid_o  (rvalid_o),
    .rdata_o   (rdata_o),
    .err_o     (err_o),
    .gpi_i     (gpi_i),
    .led_o     (led_o)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fmask(input logic [1:0] idx);
    case (idx)
      2'd0:    return 32'h0000_00FF;
      2'd1:    return 32'h0000_FFFF;
      2'd2:    return 32'h00FF_FFFF;
      default: return 32'h0000_00FF;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // Issue one request at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic bus(input logic we, input logic [2:0] ofs, input logic [3:0] be,
                     input logic [31:0] d, output logic [31:0] rd, output logic er);
    req_i   = 1'b1;
    we_i    = we;
    be_i    = be;
    addr_i  = 32'h1000_0000 | {27'd0, ofs, 2'b00};
    wdata_i = d;
    #1;
    check("gnt", 32'(gnt_o), 32'd1);
    @(posedge clk_sys);
    #1;
    req_i   = 1'b0;
    we_i    = 1'b0;
    be_i    = '0;
    wdata_i = '0;
    check("rvalid", 32'(rvalid_o), 32'd1);
    rd = rdata_o;
    er = err_o;
  endtask

  task automatic wr(input logic [2:0] ofs, input logic [3:0] be, input logic [31:0] d,
                    input string tag);
    logic [31:0] rd;
    logic        er;
    bus(1'b1, ofs, be, d, rd, er);
    check({tag, "_wrdata"}, rd, 32'd0);
    check({tag, "_wrerr"}, 32'(er), 32'(ofs > 3'd4));
    if (ofs < 3'd4) model[ofs[1:0]] = merge(model[ofs[1:0]], d, be) & fmask(ofs[1:0]);
  endtask

  task automatic rd_chk(input logic [2:0] ofs, input string tag);
    logic [31:0] rd, exp;
    logic        er;
    bus(1'b0, ofs, 4'hF, 32'd0, rd, er);
    if (ofs < 3'd4)       exp = model[ofs[1:0]];
    else if (ofs == 3'd4) exp = 32'(gpi_i);
    else                  exp = 32'd0;
    check({tag, "_rdata"}, rd, exp);
    check({tag, "_err"}, 32'(er), 32'(ofs > 3'd4));
  endtask

  // After a BLINK_DIV write the phase after edge E+t is (t/(d+1)) mod 2,
  // and led_o follows one edge later.
  task automatic blink_run(input int unsigned d);
    int unsigned ph;
    wr(3'd2, 4'hF, d, "blink_div");
    for (int t = 0; t < 4 * (int'(d) + 1); t++) begin
      @(posedge clk_sys);
      #1;
      ph = (unsigned'(t) / (d + 1)) % 2;
      check("blink_led", 32'(led_o), ph);
    end
  endtask

  task automatic pwm_run(input int unsigned duty);
    int unsigned high;
    wr(3'd3, 4'hF, duty, "pwm_duty");
    repeat (2) @(posedge clk_sys);
    #1;
    high = 0;
    for (int t = 0; t < 256; t++) begin
      high += 32'(led_o[0]);
      check("pwm_others", 32'(led_o[NumLeds-1:1]), 32'd0);
      @(posedge clk_sys);
      #1;
    end
    check("pwm_high_count", high, duty);
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 4; i++) model[i] = '0;

    // Reset state
    #2;
    check("rst_led", 32'(led_o), 32'd0);
    check("rst_rvalid", 32'(rvalid_o), 32'd0);
    #20 rst_sys_n = 1'b1;
    @(posedge clk_sys);
    #1;
    for (int o = 0; o < 5; o++) begin
      rd_chk(3'(o), "reset_read");
      check("reset_led", 32'(led_o), 32'd0);
    end
    @(posedge clk_sys);
    #1;
    check("rvalid_single", 32'(rvalid_o), 32'd0);

    // Static OUT, two-cycle latency to led_o
    wr(3'd0, 4'hF, 32'hA5, "out_a5");
    check("out_latency_early", 32'(led_o), 32'd0);
    @(posedge clk_sys);
    #1;
    check("out_latency", 32'(led_o), 32'hA5);
    wr(3'd0, 4'b0010, 32'hFF00, "out_be1");
    rd_chk(3'd0, "out_be1_read");
    check("out_be1_led", 32'(led_o), 32'hA5);

    // Unmapped and GPI writes: no state change
    wr(3'd6, 4'hF, 32'hFFFF_FFFF, "unmapped6");
    wr(3'd4, 4'hF, 32'hFFFF_FFFF, "gpi_write");
    rd_chk(3'd6, "unmapped6");
    rd_chk(3'd7, "unmapped7");
    for (int o = 0; o < 5; o++) rd_chk(3'(o), "after_unmapped");

    // Random register writes with random byte enables
    for (int n = 0; n < 16; n++) begin
      v = $urandom;
      wr(3'($urandom_range(0, 3)), 4'($urandom), v, "rand_wr");
      for (int o = 0; o < 4; o++) rd_chk(3'(o), "rand_rd");
    end

    // Random static patterns
    wr(3'd1, 4'hF, 32'd0, "mode_static");
    for (int n = 0; n < 4; n++) begin
      v = 32'($urandom_range(0, 255));
      wr(3'd0, 4'hF, v, "rand_out");
      @(posedge clk_sys);
      #1;
      check("rand_static_led", 32'(led_o), v);
    end

    // Blink on LED0
    wr(3'd1, 4'hF, 32'h0001, "mode_blink");
    wr(3'd0, 4'hF, 32'h01, "out_01");
    wr(3'd2, 4'hF, 32'd3, "blink_div3");
    repeat (5) @(posedge clk_sys);
    #1;
    check("blink_high_before_restart", 32'(led_o), 32'd1);
    blink_run(3);
    for (int n = 0; n < 3; n++) blink_run($urandom_range(0, 6));

    // PWM on LED0
    wr(3'd1, 4'hF, 32'h0002, "mode_pwm");
    pwm_run(64);
    pwm_run(0);
    pwm_run(255);
    pwm_run($urandom_range(1, 254));

    // GPI synchronisation latency
    for (int n = 0; n < 3; n++) begin
      #3 gpi_i = (n == 0) ? 8'h3C : 8'($urandom);
      @(posedge clk_sys);
      @(posedge clk_sys);
      #1;
      rd_chk(3'd4, "gpi");
    end

    // Back-to-back read / write / read
    req_i  = 1'b1;
    we_i   = 1'b0;
    be_i   = 4'hF;
    addr_i = 32'h1000_0000;
    @(posedge clk_sys);
    #1;
    check("b2b_rvalid0", 32'(rvalid_o), 32'd1);
    check("b2b_rdata0", rdata_o, model[0]);
    we_i    = 1'b1;
    wdata_i = 32'h5A;
    @(posedge clk_sys);
    #1;
    model[0] = 32'h5A;
    check("b2b_rvalid1", 32'(rvalid_o), 32'd1);
    check("b2b_rdata1", rdata_o, 32'd0);
    check("b2b_err1", 32'(err_o), 32'd0);
    we_i    = 1'b0;
    wdata_i = '0;
    @(posedge clk_sys);
    #1;
    req_i = 1'b0;
    check("b2b_rvalid2", 32'(rvalid_o), 32'd1);
    check("b2b_rdata2", rdata_o, 32'h5A);
    @(posedge clk_sys);
    #1;
    check("b2b_rvalid_end", 32'(rvalid_o), 32'd0);

    // Reset while a request is pending: no response after release
    req_i  = 1'b1;
    addr_i = 32'h1000_0000;
    #2 rst_sys_n = 1'b0;
    #1 req_i = 1'b0;
    @(posedge clk_sys);
    #1;
    check("midrst_rvalid", 32'(rvalid_o), 32'd0);
    check("midrst_led", 32'(led_o), 32'd0);
    #3 rst_sys_n = 1'b1;
    for (int i = 0; i < 4; i++) model[i] = '0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk_sys);
      #1;
      check("post_rst_rvalid", 32'(rvalid_o), 32'd0);
    end
    for (int o = 0; o < 4; o++) rd_chk(3'(o), "post_rst_read");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
